// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings and constants for the 6-stage pipeline controller.
//   state_t       controller state encoding (RUN / MEMWAIT / HALTED)
//   STG_*         stage indices into stage_vld ([0]=IF .. [5]=WB)
//   R_*           inter-stage register indices into reg_ld / reg_bub ([0]=IF/ID .. [4]=MEM/WB)
//   NOP_INSTR     value muxed into a register's Din when it is bubbled
//   LD_* / BUB_*  load / bubble patterns for each pipeline action
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  localparam int unsigned N_STG = 6;
  localparam int unsigned N_REG = 5;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_RR  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

  localparam int unsigned R_IFID  = 0;
  localparam int unsigned R_IDRR  = 1;
  localparam int unsigned R_RREX  = 2;
  localparam int unsigned R_EXMEM = 3;
  localparam int unsigned R_MEMWB = 4;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam logic [N_REG-1:0] LD_NONE = 5'b00000;
  localparam logic [N_REG-1:0] LD_ALL  = 5'b11111;
  localparam logic [N_REG-1:0] LD_LU   = 5'b11100;
  localparam logic [N_REG-1:0] LD_MW   = 5'b10000;
  localparam logic [N_REG-1:0] BUB_LU  = 5'b00100;
  localparam logic [N_REG-1:0] BUB_BR  = 5'b00111;
  localparam logic [N_REG-1:0] BUB_MW  = 5'b10000;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: saturating stall / flush performance counters.
//   clk, reset   clock and asynchronous active-high reset
//   stall_inc    count one stall cycle
//   flush_inc    count one taken-branch flush
//   stall_cnt    saturating stall-cycle count
//   flush_cnt    saturating flush count
module pipe_ctrl_perf
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: sequences the five inter-stage registers of the 6-stage core.
//   clk, reset    clock and asynchronous active-high reset
//   load_use_haz  RR instruction needs the load result in EX
//   br_taken      EX resolves a redirect
//   mem_busy      MEM access not complete
//   halt_wb       HLT in WB
//   pc_ld         PC load enable (combinational, forced 0 in reset)
//   reg_ld        per-register load enables (combinational, forced 0 in reset)
//   reg_bub       per-register bubble selects (combinational, forced 0 in reset)
//   stage_vld     registered per-stage valid bits
//   halted        registered, core stopped until reset
//   mem_timeout   registered sticky MEM wait timeout flag
//   stall_cnt     saturating count of pc_ld=0 cycles
//   flush_cnt     saturating count of taken-branch flushes
// Build option: PIPE_PERF_CNT_EN enables the performance counters; otherwise
// stall_cnt and flush_cnt are tied to zero.
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_haz,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             halt_wb,
  output logic             pc_ld,
  output logic [4:0]       reg_ld,
  output logic [4:0]       reg_bub,
  output logic [5:0]       stage_vld,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [N_STG-1:0]    vld_q;
  logic                halted_q;
  logic                mto_q;

  logic                pc_ld_c;
  logic [N_REG-1:0]    reg_ld_c;
  logic [N_REG-1:0]    reg_bub_c;
  logic                set_mto_c;
  logic                stall_inc_c;
  logic                flush_inc_c;

  logic                hl_c, mu_c, br_c, lu_c, tmo_hit_c;

  // Events only count when the stage they refer to holds a real instruction.
  assign hl_c = halt_wb      & vld_q[STG_WB];
  assign mu_c = mem_busy     & vld_q[STG_MEM];
  assign br_c = br_taken     & vld_q[STG_EX];
  assign lu_c = load_use_haz & vld_q[STG_RR] & vld_q[STG_EX];

  assign tmo_hit_c = (state_q == MEMWAIT) && (MEM_TIMEOUT != 0) &&
                     (wcnt_q == WAIT_W'(MEM_TIMEOUT));

  // Next state and pipeline controls; priority hl/timeout > mu > br > lu.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    pc_ld_c     = 1'b0;
    reg_ld_c    = LD_NONE;
    reg_bub_c   = LD_NONE;
    set_mto_c   = 1'b0;
    stall_inc_c = 1'b0;
    flush_inc_c = 1'b0;

    unique case (state_q)
      RUN, MEMWAIT: begin
        if (hl_c || tmo_hit_c) begin
          state_d   = HALTED;
          set_mto_c = tmo_hit_c;
        end else if (mu_c) begin
          // Entry cycle already presents MEMWAIT controls.
          state_d   = MEMWAIT;
          wcnt_d    = (state_q == RUN) ? '0 : wcnt_q + WAIT_W'(1);
          reg_ld_c  = LD_MW;
          reg_bub_c = BUB_MW;
        end else begin
          state_d = RUN;
          if (br_c) begin
            pc_ld_c     = 1'b1;
            reg_ld_c    = LD_ALL;
            reg_bub_c   = BUB_BR;
            flush_inc_c = 1'b1;
          end else if (lu_c) begin
            reg_ld_c  = LD_LU;
            reg_bub_c = BUB_LU;
          end else begin
            pc_ld_c  = 1'b1;
            reg_ld_c = LD_ALL;
          end
        end
        stall_inc_c = ~pc_ld_c;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, wait counter and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      wcnt_q   <= '0;
      halted_q <= 1'b0;
      mto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      halted_q <= (state_d == HALTED);
      mto_q    <= mto_q | set_mto_c;
    end
  end

  // Valid bits follow the data: bubble clears, load copies upstream, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      if (state_q != HALTED) vld_q[STG_IF] <= 1'b1;
      for (int i = 0; i < int'(N_REG); i++) begin
        if (reg_bub_c[i])     vld_q[i+1] <= 1'b0;
        else if (reg_ld_c[i]) vld_q[i+1] <= vld_q[i];
      end
    end
  end

  assign pc_ld       = pc_ld_c & ~reset;
  assign reg_ld      = reset ? LD_NONE : reg_ld_c;
  assign reg_bub     = reset ? LD_NONE : reg_bub_c;
  assign stage_vld   = vld_q;
  assign halted      = halted_q;
  assign mem_timeout = mto_q;

`ifdef PIPE_PERF_CNT_EN
  pipe_ctrl_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk),
    .reset     (reset),
    .stall_inc (stall_inc_c),
    .flush_inc (flush_inc_c),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  logic unused_perf;
  assign unused_perf = ^{stall_inc_c, flush_inc_c};
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb_pipe_stage_ctrl: scoreboard bench for pipe_stage_ctrl with a behavioural pipeline model.
module tb_pipe_stage_ctrl;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMO   = 4;
  localparam longint unsigned CMAX = (64'd1 << CNT_W) - 64'd1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load_use_haz = 1'b0;
  logic             br_taken = 1'b0;
  logic             mem_busy = 1'b0;
  logic             halt_wb = 1'b0;
  logic             pc_ld;
  logic [4:0]       reg_ld;
  logic [4:0]       reg_bub;
  logic [5:0]       stage_vld;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_use_haz (load_use_haz),
    .br_taken     (br_taken),
    .mem_busy     (mem_busy),
    .halt_wb      (halt_wb),
    .pc_ld        (pc_ld),
    .reg_ld       (reg_ld),
    .reg_bub      (reg_bub),
    .stage_vld    (stage_vld),
    .halted       (halted),
    .mem_timeout  (mem_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  typedef struct packed {
    logic             pc;
    logic [4:0]       ld;
    logic [4:0]       bub;
    logic [5:0]       vld;
    logic             hlt;
    logic             mto;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: one valid flag per stage, a halt flag, a "waiting on MEM" flag.
  bit [5:0]        m_vld;
  bit              m_halt, m_to, m_wait;
  int              m_wcnt;
  longint unsigned m_sc, m_fc;

  function automatic exp_t snapshot();
    exp_t e;
    e.pc  = 1'b0;
    e.ld  = '0;
    e.bub = '0;
    e.vld = m_vld;
    e.hlt = m_halt;
    e.mto = m_to;
`ifdef PIPE_PERF_CNT_EN
    e.sc = CNT_W'(m_sc);
    e.fc = CNT_W'(m_fc);
`else
    e.sc = '0;
    e.fc = '0;
`endif
    return e;
  endfunction

  task automatic rst_cyc();
    @(posedge clk); #1;
    reset = 1'b1;
    load_use_haz = 1'b0; br_taken = 1'b0; mem_busy = 1'b0; halt_wb = 1'b0;
    m_vld = '0; m_halt = 0; m_to = 0; m_wait = 0; m_wcnt = 0; m_sc = 0; m_fc = 0;
    q.push_back(snapshot());
  endtask

  task automatic cyc(input bit i_lu, input bit i_br, input bit i_mu, input bit i_hl);
    exp_t e;
    bit   hl, mu, br, lu, tmo_now, stop;
    bit   stall;
    bit [5:0] nv;
    @(posedge clk); #1;
    reset = 1'b0;
    load_use_haz = i_lu; br_taken = i_br; mem_busy = i_mu; halt_wb = i_hl;
    e  = snapshot();
    hl = i_hl & m_vld[5];
    mu = i_mu & m_vld[4];
    br = i_br & m_vld[3];
    lu = i_lu & m_vld[2] & m_vld[3];
    tmo_now = m_wait && (m_wcnt == int'(TMO));
    stop = 0;
    if (m_halt) begin
      // frozen: all controls stay 0
    end else if (hl || tmo_now) begin
      stop = 1;
      if (tmo_now) m_to = 1;
    end else if (mu) begin
      e.ld = 5'b10000; e.bub = 5'b10000;
      m_wcnt = m_wait ? m_wcnt + 1 : 0;
      m_wait = 1;
    end else begin
      m_wait = 0;
      if (br) begin
        e.pc = 1; e.ld = 5'b11111; e.bub = 5'b00111;
        if (m_fc < CMAX) m_fc++;
      end else if (lu) begin
        e.ld = 5'b11100; e.bub = 5'b00100;
      end else begin
        e.pc = 1; e.ld = 5'b11111;
      end
    end
    q.push_back(e);
    stall = !m_halt && !e.pc;
    if (stall && m_sc < CMAX) m_sc++;
    nv = m_vld;
    for (int i = 0; i < 5; i++) begin
      if (e.bub[i])     nv[i+1] = 1'b0;
      else if (e.ld[i]) nv[i+1] = m_vld[i];
    end
    if (!m_halt) nv[0] = 1'b1;
    m_vld = nv;
    if (stop) m_halt = 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_ld",       64'(pc_ld),       64'(e.pc));
        chk("reg_ld",      64'(reg_ld),      64'(e.ld));
        chk("reg_bub",     64'(reg_bub),     64'(e.bub));
        chk("stage_vld",   64'(stage_vld),   64'(e.vld));
        chk("halted",      64'(halted),      64'(e.hlt));
        chk("mem_timeout", 64'(mem_timeout), 64'(e.mto));
        chk("stall_cnt",   64'(stall_cnt),   64'(e.sc));
        chk("flush_cnt",   64'(flush_cnt),   64'(e.fc));
      end
    end
  end

  initial begin
    bit mb;
    int r;
    rst_cyc(); rst_cyc();
    idle(7);                                   // fill: vld 000001 .. 111111
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);          // load-use stall x2
    idle(4);
    cyc(1, 1, 0, 0);                           // branch overrides load-use
    idle(4);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0); // MEM wait with pending branch
    cyc(0, 1, 0, 0);                           // branch applied on release
    idle(5);
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 0); // stuck MEM -> timeout halt
    idle(3);
    rst_cyc(); idle(7);
    cyc(1, 0, 0, 1);                           // halt during load-use
    idle(3);
    rst_cyc(); idle(7);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    rst_cyc();                                 // async reset mid-MEMWAIT
    idle(2);

    mb = 0;
    for (int ep = 0; ep < 20; ep++) begin
      rst_cyc();
      for (int c = 0; c < 80; c++) begin
        r  = int'($urandom_range(0, 99));
        mb = (mb && r < 80) || ($urandom_range(0, 99) < 15);
        cyc($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 25, mb,
            $urandom_range(0, 199) < 3);
      end
    end

    @(negedge clk); #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
